if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Drives the if_pc/if_inst pair consumed by the IF/ID pipeline register.
- Honours the shared 6-bit stall vector and the flush redirect.
- Raises stallreq_if to the stall controller while a fetch is incomplete. The controller then asserts stall[1:0], which inserts a bubble into ID.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  6  pipeline stall vector; bit0 = IF hold, bit2 = ID hold.
- flush  in  1  exception/eret redirect; highest priority.
- new_pc  in  ADDR_W  redirect target, valid with flush.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_i  in  ADDR_W  branch target, valid with branch_flag_i.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; at least 1 cycle after grant.
- imem_rdata  in  DATA_W  instruction word.
- if_pc  out  ADDR_W  PC of the presented instruction.
- if_inst  out  DATA_W  instruction presented, or 0 (NOP) when not ready.
- stallreq_if  out  1  fetch not complete; requests a stall.

Behaviour:
- State machine REQ → WAIT → DONE. Internal registers: pc, inst_q, kill, br_pend, br_tgt.
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=REQ, kill=0, br_pend=0, inst_q=0. imem_rvalid is ignored in the reset cycle.
- Outputs after reset: imem_req=1, imem_addr=RESET_PC, if_inst=0, stallreq_if=1, if_pc=RESET_PC.
- REQ state:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt → WAIT.
  - imem_addr may change while not yet granted; this happens only on flush.
- WAIT state:
  - imem_req=0.
  - On imem_rvalid with kill=1: discard the data, clear kill, → REQ. pc already holds the redirect target.
  - On imem_rvalid with kill=0: inst_q<=imem_rdata, → DONE.
  - imem_rvalid in REQ or DONE is ignored.
- DONE state:
  - if_inst=inst_q, stallreq_if=0.
  - If stall[0]=0: pc<=next, → REQ. The consuming register captures at this same edge.
  - next = branch_target_i if (branch_flag_i && !stall[2]); else br_tgt if br_pend (then clear br_pend); else pc+4.
  - If stall[0]=1: hold all state.
- Outside DONE: if_inst=0, stallreq_if=1. if_pc=pc in all states.
- Delay slot:
  - branch_flag_i && !stall[2] while state≠DONE: latch br_pend=1, br_tgt=branch_target_i. The instruction currently fetching is the delay slot; the target is used when it leaves DONE.
  - A new branch overwrites br_tgt.
- Flush (overrides stall and branch, any state): pc<=new_pc, br_pend<=0.
  - From REQ: stay in REQ with the new address.
  - From WAIT: kill<=1, stay in WAIT. If rvalid arrives in the same cycle, drop it and go to REQ.
  - From DONE: → REQ.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFFFFFC+4 wraps to 0.
- Latency: 0 wait-state memory (gnt same cycle as req, rvalid next cycle) gives a 3-cycle throughput per instruction: REQ, WAIT, DONE.

Optional Feature:
- IF_ADEL_CHK_EN defined:
  - Adds output if_adel (1 bit).
  - If pc[1:0]≠0 in REQ, no request is issued. State goes directly to DONE with inst_q=0 and if_adel=1.
  - if_adel clears when leaving DONE or on flush.
- Undefined: no port; pc[1:0] is passed to memory unchanged.

Decomposition:
- Shared defines file holds InstAddrBus/InstBus widths, ZeroWord, NOP encoding, stall-bit indices (STALL_IF=0, STALL_ID=2), and FSM state encodings.
- No sub-module needed. Optionally split out fetch_branch_latch (br_pend/br_tgt).

Test Plan:
- Reset with RESET_PC=32'hBFC00000 and 0 wait-state memory → imem_addr sequence BFC00000, BFC00004, BFC00008. if_inst valid every 3rd cycle; stallreq_if low only in DONE.
- stall=6'b000011 for 4 cycles while in DONE with inst 32'h24010005 → if_pc/if_inst held constant. No new imem_req; pc advances by 4 only after stall clears.
- branch_flag_i=1, target 32'h00000100 while fetching delay slot at 0x0C → 0x0C is presented, then the next request is 0x100. br_pend clears.
- flush with new_pc=32'h00000380 while in WAIT; rvalid next cycle with 32'hDEADBEEF → DEADBEEF is never presented. Next request is 0x380.
- gnt held low for 5 cycles, then flush → imem_addr switches to new_pc while req stays high. The granted address is new_pc.
- rst_n low in WAIT, rvalid in the same cycle → response ignored. State is REQ at RESET_PC and if_inst=0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, stall-vector bit positions and fetch FSM encoding for the
// instruction-fetch stage.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = ZERO_WORD;

  localparam int STALL_IF = 0;
  localparam int STALL_ID = 2;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_branch_latch.sv
// Holds a branch target resolved while the delay-slot instruction is still
// being fetched, so the PC can be redirected once that slot is presented.
module if_fetch_branch_latch #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] tgt_i,
  input  logic              clr_i,
  output logic              br_pend_o,
  output logic [ADDR_W-1:0] br_tgt_o
);

  logic              br_pend_q;
  logic [ADDR_W-1:0] br_tgt_q;

  // Clear wins over set: a flush discards any branch resolved in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
    end else if (clr_i) begin
      br_pend_q <= 1'b0;
    end else if (set_i) begin
      br_pend_q <= 1'b1;
      br_tgt_q  <= tgt_i;
    end
  end

  assign br_pend_o = br_pend_q;
  assign br_tgt_o  = br_tgt_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, single-outstanding req/gnt/rvalid fetch.
// Optional misaligned-PC detection (if_adel output) with `define IF_ADEL_CHK_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
`ifdef IF_ADEL_CHK_EN
  output logic              if_adel,
`endif
  output logic              stallreq_if
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              kill_q, kill_d;
`ifdef IF_ADEL_CHK_EN
  logic              adel_q, adel_d;
`endif

  logic              br_now;
  logic              leave_done;
  logic              br_pend;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] pc_seq;
  logic              unused_stall;

  assign unused_stall = ^{stall[5:3], stall[1]};

  assign br_now     = branch_flag_i && !stall[STALL_ID];
  assign leave_done = (state_q == ST_DONE) && !stall[STALL_IF];
  // A branch resolved in the same cycle beats an older pending one.
  assign pc_seq     = br_now  ? branch_target_i :
                      br_pend ? br_tgt : pc_q + ADDR_W'(4);

  if_fetch_branch_latch #(
    .ADDR_W (ADDR_W)
  ) u_branch_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (br_now && (state_q != ST_DONE)),
    .tgt_i     (branch_target_i),
    .clr_i     (flush || leave_done),
    .br_pend_o (br_pend),
    .br_tgt_o  (br_tgt)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    kill_d   = kill_q;
    imem_req = 1'b0;
`ifdef IF_ADEL_CHK_EN
    adel_d   = adel_q;
`endif

    case (state_q)
      ST_REQ: begin
`ifdef IF_ADEL_CHK_EN
        if (pc_q[1:0] != 2'b00) begin
          state_d = ST_DONE;
          inst_d  = '0;
          adel_d  = 1'b1;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) state_d = ST_WAIT;
        end
`else
        imem_req = 1'b1;
        if (imem_gnt) state_d = ST_WAIT;
`endif
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d  = imem_rdata;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!stall[STALL_IF]) begin
          pc_d    = pc_seq;
          state_d = ST_REQ;
`ifdef IF_ADEL_CHK_EN
          adel_d  = 1'b0;
`endif
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Redirect overrides everything. A request accepted in the flush cycle
    // still gets a response, so it is waited out and dropped.
    if (flush) begin
      pc_d = new_pc;
`ifdef IF_ADEL_CHK_EN
      adel_d = 1'b0;
`endif
      case (state_q)
        ST_REQ: begin
          state_d = (imem_req && imem_gnt) ? ST_WAIT : ST_REQ;
          kill_d  = imem_req && imem_gnt;
        end
        ST_WAIT: begin
          state_d = imem_rvalid ? ST_REQ : ST_WAIT;
          kill_d  = !imem_rvalid;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      kill_q  <= 1'b0;
`ifdef IF_ADEL_CHK_EN
      adel_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      kill_q  <= kill_d;
`ifdef IF_ADEL_CHK_EN
      adel_q  <= adel_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = pc_q;
  assign if_inst     = (state_q == ST_DONE) ? inst_q : DATA_W'(NOP_INST);
  assign stallreq_if = (state_q != ST_DONE);
`ifdef IF_ADEL_CHK_EN
  assign if_adel     = adel_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed scenarios followed by randomized traffic for if_fetch, checked
// against an instruction-stream reference model and a behavioural memory.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, branch_flag_i, imem_req, imem_gnt, imem_rvalid, stallreq_if;
  logic [5:0]  stall;
  logic [31:0] new_pc, branch_target_i, imem_addr, imem_rdata, if_pc, if_inst;
`ifdef IF_ADEL_CHK_EN
  logic        if_adel;
`endif

  always #5 clk = ~clk;

  if_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
`ifdef IF_ADEL_CHK_EN
    .if_adel         (if_adel),
`endif
    .stallreq_if     (stallreq_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural instruction memory: content is a fixed function of address.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F0F;
  endfunction

  // Stimulus knobs
  logic        d_rst_n = 1'b0, d_flush = 1'b0, d_br = 1'b0;
  logic [5:0]  d_stall = '0;
  logic [31:0] d_new_pc = '0, d_tgt = '0;
  int          mem_lat = 0;      // >=0: gnt always high, fixed latency; <0: random
  bit          gnt_low = 1'b0;

  // Memory responder state
  bit          mb_busy = 1'b0;
  logic [31:0] mb_addr = '0;
  int          mb_cnt  = 0;
  logic [31:0] last_grant = '0;

  // Reference model: PC of the next instruction to present, pending branch
  logic [31:0] m_pc = RST_PC;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt = '0;

  int          cycle = 0;
  int          idle = 0, max_idle = 0, consumed = 0;
  int          done_q[$];
  logic [31:0] grant_q[$];

  task automatic step();
    bit br_now;
    imem_gnt    = gnt_low ? 1'b0 : ((mem_lat >= 0) ? 1'b1 : ($urandom_range(0, 2) != 0));
    imem_rvalid = mb_busy && (mb_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mb_addr) : $urandom;
    rst_n           = d_rst_n;
    stall           = d_stall;
    flush           = d_flush;
    new_pc          = d_new_pc;
    branch_flag_i   = d_br;
    branch_target_i = d_tgt;
    #1;
    check("if_pc", if_pc, m_pc);
    check("if_inst", if_inst, stallreq_if ? 32'h0 : mem_word(m_pc));
    if (imem_req) check("imem_addr", imem_addr, m_pc);
    if (stallreq_if) idle++; else idle = 0;
    if (idle > max_idle) max_idle = idle;
    if (!stallreq_if) done_q.push_back(cycle);
    if (imem_req && imem_gnt && d_rst_n) grant_q.push_back(imem_addr);

    if (!d_rst_n) begin
      m_pc = RST_PC; m_pend = 1'b0;
    end else if (d_flush) begin
      m_pc = d_new_pc; m_pend = 1'b0;
    end else begin
      br_now = d_br && !d_stall[2];
      if (!stallreq_if) begin
        if (!d_stall[0]) begin
          $display("[TB] cycle %0d fetched pc=%h inst=%h", cycle, if_pc, if_inst);
          consumed++;
          m_pc   = br_now ? d_tgt : (m_pend ? m_tgt : m_pc + 32'd4);
          m_pend = 1'b0;
        end
      end else if (br_now) begin
        m_pend = 1'b1; m_tgt = d_tgt;
      end
    end

    if (!d_rst_n) begin
      mb_busy = 1'b0;
    end else begin
      if (mb_busy) begin
        if (mb_cnt == 0) mb_busy = 1'b0; else mb_cnt--;
      end
      if (imem_req && imem_gnt) begin
        mb_busy    = 1'b1;
        mb_addr    = imem_addr;
        last_grant = imem_addr;
        mb_cnt     = (mem_lat >= 0) ? mem_lat : $urandom_range(0, 2);
      end
    end
    cycle++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_until_present(input string tag);
    int n = 0;
    while (stallreq_if && n < 20) begin
      step();
      n++;
    end
    check({tag, "_reach_done"}, {31'b0, stallreq_if}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst_n = 1'b0; stall = '0; flush = 1'b0; new_pc = '0; branch_flag_i = 1'b0;
    branch_target_i = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_ovr[RST_PC + 32'hC] = 32'h2401_0005;
    mem_ovr[32'h0000_0100] = 32'hDEAD_BEEF;
    @(negedge clk);

    // Reset state and zero-wait-state throughput
    d_rst_n = 1'b0;
    step();
    d_rst_n = 1'b1;
    check("rst_req", {31'b0, imem_req}, 32'h1);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_stallreq", {31'b0, stallreq_if}, 32'h1);
    check("rst_inst", if_inst, 32'h0);
    done_q.delete(); grant_q.delete();
    start = cycle;
    repeat (9) step();
    check("t1_ngrant", grant_q.size(), 3);
    check("t1_ndone", done_q.size(), 3);
    for (int i = 0; i < 3 && i < grant_q.size(); i++)
      check("t1_grant_addr", grant_q[i], RST_PC + 32'(4 * i));
    for (int i = 0; i < 3 && i < done_q.size(); i++)
      check("t1_done_cycle", done_q[i] - start, 32'(3 * i + 2));

    // Hold in DONE under stall
    step_until_present("t2");
    check("t2_pc", if_pc, RST_PC + 32'hC);
    d_stall = 6'b000011;
    repeat (4) begin
      step();
      check("t2_hold_inst", if_inst, 32'h2401_0005);
      check("t2_hold_pc", if_pc, RST_PC + 32'hC);
      check("t2_no_req", {31'b0, imem_req}, 32'h0);
    end
    d_stall = '0;
    step();
    check("t2_next_req", {31'b0, imem_req}, 32'h1);
    check("t2_next_addr", imem_addr, RST_PC + 32'h10);

    // Branch resolved during delay-slot fetch
    gnt_low = 1'b1; d_flush = 1'b1; d_new_pc = 32'h8;
    step();
    gnt_low = 1'b0; d_flush = 1'b0;
    check("t3_redirect", imem_addr, 32'h8);
    step_until_present("t3a");
    step();
    d_br = 1'b1; d_tgt = 32'h100;
    step();
    d_br = 1'b0;
    step_until_present("t3b");
    check("t3_delay_slot", if_pc, 32'hC);
    step();
    check("t3_target_addr", imem_addr, 32'h100);

    // Flush while waiting; stale response is dropped
    mem_lat = 1;
    step();
    d_flush = 1'b1; d_new_pc = 32'h380;
    step();
    d_flush = 1'b0;
    check("t4_still_wait", {31'b0, imem_req}, 32'h0);
    step();
    check("t4_req", {31'b0, imem_req}, 32'h1);
    check("t4_addr", imem_addr, 32'h380);
    step_until_present("t4");
    check("t4_inst", if_inst, mem_word(32'h380));
    mem_ovr.delete(32'h100);

    // No grant for 5 cycles, then flush changes the pending address
    step();
    gnt_low = 1'b1;
    repeat (5) begin
      step();
      check("t5_req_held", {31'b0, imem_req}, 32'h1);
      check("t5_addr_held", imem_addr, 32'h384);
    end
    d_flush = 1'b1; d_new_pc = 32'h200;
    step();
    d_flush = 1'b0;
    check("t5_new_addr", imem_addr, 32'h200);
    gnt_low = 1'b0; mem_lat = 0;
    step();
    check("t5_granted", last_grant, 32'h200);

    // Reset while waiting, response arrives in the reset cycle
    d_rst_n = 1'b0;
    step();
    d_rst_n = 1'b1;
    check("t6_stallreq", {31'b0, stallreq_if}, 32'h1);
    check("t6_inst", if_inst, 32'h0);
    check("t6_addr", imem_addr, RST_PC);
    check("t6_req", {31'b0, imem_req}, 32'h1);
    step_until_present("t6");

    // PC wrap-around
    d_flush = 1'b1; d_new_pc = 32'hFFFF_FFFC;
    step();
    d_flush = 1'b0;
    check("t7_addr", imem_addr, 32'hFFFF_FFFC);
    step_until_present("t7");
    step();
    check("t7_wrap", imem_addr, 32'h0);

    // Randomized traffic
    mem_lat = -1; max_idle = 0; consumed = 0;
    for (int i = 0; i < 2000; i++) begin
      d_rst_n  = ($urandom_range(0, 299) != 0);
      d_flush  = ($urandom_range(0, 39) == 0);
      d_new_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      d_br     = ($urandom_range(0, 7) == 0);
      d_tgt    = $urandom & 32'hFFFF_FFFC;
      d_stall  = {$urandom_range(0, 1) == 1'b1, 1'b0, $urandom_range(0, 4) == 0,
                  1'b0, $urandom_range(0, 1) == 1'b1, $urandom_range(0, 3) == 0};
      step();
    end
    check("rand_max_idle_ok", {31'b0, max_idle <= 150}, 32'h1);
    check("rand_progress", {31'b0, consumed > 100}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
